ddr_sdram_responder: RTL and testbench
======================================

# ddr_sdram_responder

Synthesizable device-side responder for the `ddr_sdram` controller command bus. It decodes RAS/CAS/WE commands, tracks an open row per bank, stores write bursts into a small on-chip array, and returns read bursts with DQS strobes after CAS latency. It sits opposite the controller in system benches and FPGA loopback builds. It replaces an external DDR part for controller bring-up, at one data beat per SYS_CLK_100M cycle.

## Interface
- BURST_LENGTH, 2: beats per READ/WRITE; must be 2, 4 or 8.
- CAS_LATENCY, 2: cycles from READ command to first read beat; valid range 2–3.
- ROW_BITS, 2: low row-address bits used for storage indexing.
- COL_BITS, 4: low column-address bits used for storage indexing.
- Storage depth is 2^(2+ROW_BITS+COL_BITS) words of 16 bits, indexed {BA, row[ROW_BITS-1:0], col[COL_BITS-1:0]}.

Ports:
- SYS_CLK_100M  in  1  sole clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- CKE  in  1  clock enable; when low, the command is treated as NOP.
- RAS, CAS, WE  in  1 each  active-low command lines.
- BA  in  2  bank address.
- ADDR_RAM  in  13  row address (ACTIVE), column address (READ/WRITE), or mode word (LOAD MODE).
- DM  in  2  write byte masks: DM[1] masks [15:8], DM[0] masks [7:0]; 1 means masked.
- DATA_WR  in  16  write beat data.
- DATA_RD  out  16  read beat data.
- DQS_RD  out  2  read strobe, both bits identical.
- DATA_OE  out  1  high while DATA_RD carries a valid beat.
- MODE_REG  out  13  last LOAD MODE word.
- REF_COUNT  out  16  AUTO REFRESH counter.
- ERR  out  1  sticky protocol-error flag; cleared only by RST.

## Operation
- Command decode ({RAS,CAS,WE}) happens only when CKE=1:
  - 111 NOP
  - 011 ACTIVE
  - 101 READ
  - 100 WRITE
  - 010 PRECHARGE (ADDR_RAM[10]=1 closes all banks)
  - 001 AUTO REFRESH
  - 000 LOAD MODE
- Per-bank state is open flag plus row register.
  - ACTIVE on a closed bank opens it and latches ADDR_RAM[ROW_BITS-1:0].
  - ACTIVE on an already-open bank sets ERR; the row is unchanged.
- PRECHARGE clears the open flag of BA, or of all banks. Precharging a closed bank is legal.
- AUTO REFRESH increments REF_COUNT, wrapping at 16'hFFFF→0. It sets ERR if any bank is open.
- LOAD MODE: MODE_REG ← ADDR_RAM.
- READ/WRITE to a closed bank sets ERR and is otherwise ignored. READ/WRITE issued while not in IDLE sets ERR and is ignored.
- State machine:
  - IDLE: WRITE → WR_BURST; READ → RD_WAIT.
  - WR_BURST: BURST_LENGTH beats, then IDLE.
  - RD_WAIT: CAS_LATENCY-1 cycles, then RD_BURST.
  - RD_BURST: BURST_LENGTH beats, then IDLE.
- Burst addressing is sequential with wrap inside the BURST_LENGTH-aligned block. Beat i uses col = {start[COL_BITS-1:log2(BL)], (start[log2(BL)-1:0]+i) mod BL}.
- Write beats: each unmasked byte of DATA_WR is written to the array; masked bytes keep their old value.
- Read beats: DATA_RD = array word; DATA_OE=1; DQS_RD = 2'b11 on even beats, 2'b00 on odd beats.
- Outside RD_BURST: DATA_OE=0, DATA_RD=0, DQS_RD=0.
- Bank/row state updates (ACTIVE, PRECHARGE, etc.) are legal during bursts. An in-flight burst uses the row latched at its READ/WRITE.

## Timing
- Reset (async, takes effect immediately):
  - Outputs: DATA_RD=0, DQS_RD=0, DATA_OE=0, MODE_REG=0, REF_COUNT=0, ERR=0.
  - Internal: all banks closed, state IDLE.
  - The array is not cleared.
  - Reset mid-burst aborts the burst with no further array writes.
- WRITE sampled at edge T: beats are sampled at edges T+1 … T+BL. The array is updated at those edges.
- READ sampled at edge T: DATA_OE rises after edge T+CL and stays high for exactly BL cycles. DQS_RD is 0 in the preamble cycle after edge T+CL-1.
- Back-to-back: a READ/WRITE is accepted at the edge where the state returns to IDLE, i.e. the edge after the last beat. Commands sampled on the last-beat edge are rejected.
- CKE low does not stall an in-flight burst.
- Read of a word written in the same cycle returns the old value.

## Test plan
- Reset: assert RST mid-read → all outputs 0 immediately; next READ without ACTIVE → ERR=1.
- Write/read, BL=2, CL=2: ACTIVE BA=1 row=3; WRITE col=4 with beats 16'h7654 then 16'hFEDC; READ col=4.
  - DATA_OE high 2 cycles starting 2 cycles after READ.
  - DATA_RD = 7654 then FEDC; DQS_RD = 11 then 00.
- Wrap and masks, BL=4: WRITE col=6 with beats A0A1, B0B1, C0C1, D0D1 and DM=00, 01, 10, 00.
  - Cols 6, 7, 4, 5 written.
  - Col 7 low byte and col 4 high byte unchanged.
- Protocol errors, checked separately after reset:
  - WRITE to closed bank 2 → ERR=1, array unchanged.
  - ACTIVE twice on bank 0 → ERR=1.
  - READ during RD_BURST → ERR=1, burst completes normally.
- Refresh/mode:
  - LOAD MODE ADDR_RAM=13'h0022 → MODE_REG=0022.
  - 3 AUTO REFRESH with banks closed → REF_COUNT=3, ERR=0.
  - CKE=0 with REFRESH → REF_COUNT unchanged.
- Bank isolation: write 1111 to bank 0 row 0 col 0 and 2222 to bank 3 row 0 col 0; read both → 1111, 2222.

Source files
------------

// File: rtl/ddr_sdram_responder_if.sv
// Command and data bus between a ddr_sdram controller (master) and the device-side responder (slave).
interface ddr_sdram_responder_if;
  logic        CKE;
  logic        RAS;
  logic        CAS;
  logic        WE;
  logic [1:0]  BA;
  logic [12:0] ADDR_RAM;
  logic [1:0]  DM;
  logic [15:0] DATA_WR;
  logic [15:0] DATA_RD;
  logic [1:0]  DQS_RD;
  logic        DATA_OE;
  logic [12:0] MODE_REG;
  logic [15:0] REF_COUNT;
  logic        ERR;

  modport master (
    output CKE, RAS, CAS, WE, BA, ADDR_RAM, DM, DATA_WR,
    input  DATA_RD, DQS_RD, DATA_OE, MODE_REG, REF_COUNT, ERR
  );

  modport slave (
    input  CKE, RAS, CAS, WE, BA, ADDR_RAM, DM, DATA_WR,
    output DATA_RD, DQS_RD, DATA_OE, MODE_REG, REF_COUNT, ERR
  );
endinterface

// File: rtl/ddr_sdram_responder.sv
// Device-side DDR SDRAM model: decodes commands, tracks open rows per bank,
// stores write bursts in a small array and replays read bursts after CAS latency.
module ddr_sdram_responder #(
  parameter int BURST_LENGTH = 2,
  parameter int CAS_LATENCY  = 2,
  parameter int ROW_BITS     = 2,
  parameter int COL_BITS     = 4
) (
  input  logic                 SYS_CLK_100M,
  input  logic                 RST,
  ddr_sdram_responder_if.slave bus
);
  localparam int         BL_BITS   = $clog2(BURST_LENGTH);
  localparam int         ADDR_W    = 2 + ROW_BITS + COL_BITS;
  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [2:0] LAST_BEAT = 3'(BURST_LENGTH - 1);
  localparam logic [1:0] LAST_WAIT = 2'(CAS_LATENCY - 2);

  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_BURST = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_RD_BURST = 2'd3
  } state_t;

  state_t              r_state;
  logic [2:0]          r_beat;
  logic [1:0]          r_wait;
  logic [3:0]          r_open;
  logic [ROW_BITS-1:0] r_row [4];
  logic [1:0]          r_bank;
  logic [ROW_BITS-1:0] r_brow;
  logic [COL_BITS-1:0] r_col;
  logic [15:0]         r_mem [DEPTH];
  logic [15:0]         r_data_rd;
  logic [1:0]          r_dqs_rd;
  logic                r_data_oe;
  logic [12:0]         r_mode_reg;
  logic [15:0]         r_ref_count;
  logic                r_err;

  logic [2:0]          w_cmd;
  logic                w_rw_ok;
  logic [BL_BITS-1:0]  w_lo;
  logic [COL_BITS-1:0] w_col;
  logic [ADDR_W-1:0]   w_addr;

  // Command decode and burst address generation (wrap inside the aligned block)
  always_comb begin
    w_cmd   = CMD_NOP;
    w_rw_ok = 1'b0;
    if (bus.CKE) begin
      w_cmd = {bus.RAS, bus.CAS, bus.WE};
    end else begin
      w_cmd = CMD_NOP;
    end
    if ((w_cmd == CMD_RD || w_cmd == CMD_WR) && r_state == S_IDLE && r_open[bus.BA]) begin
      w_rw_ok = 1'b1;
    end else begin
      w_rw_ok = 1'b0;
    end
    w_lo   = r_col[BL_BITS-1:0] + r_beat[BL_BITS-1:0];
    w_col  = {r_col[COL_BITS-1:BL_BITS], w_lo};
    w_addr = {r_bank, r_brow, w_col};
  end

  // Storage write port: byte-masked beats, only while a write burst is in flight
  always_ff @(posedge SYS_CLK_100M) begin
    if (r_state == S_WR_BURST) begin
      if (!bus.DM[1]) begin
        r_mem[w_addr][15:8] <= bus.DATA_WR[15:8];
      end
      if (!bus.DM[0]) begin
        r_mem[w_addr][7:0] <= bus.DATA_WR[7:0];
      end
    end
  end

  // Bank table, mode word, refresh counter and sticky protocol error
  always_ff @(posedge SYS_CLK_100M or posedge RST) begin
    if (RST) begin
      r_open      <= 4'b0000;
      for (int i = 0; i < 4; i++) r_row[i] <= '0;
      r_mode_reg  <= 13'd0;
      r_ref_count <= 16'd0;
      r_err       <= 1'b0;
    end else begin
      case (w_cmd)
        CMD_ACT: begin
          if (r_open[bus.BA]) begin
            r_err <= 1'b1;
          end else begin
            r_open[bus.BA] <= 1'b1;
            r_row[bus.BA]  <= bus.ADDR_RAM[ROW_BITS-1:0];
          end
        end
        CMD_PRE: begin
          if (bus.ADDR_RAM[10]) r_open <= 4'b0000;
          else                  r_open[bus.BA] <= 1'b0;
        end
        CMD_REF: begin
          r_ref_count <= r_ref_count + 16'd1;
          if (|r_open) r_err <= 1'b1;
        end
        CMD_LMR: r_mode_reg <= bus.ADDR_RAM;
        CMD_RD, CMD_WR: begin
          if (!w_rw_ok) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Burst sequencer; read outputs are registered and default to zero outside RD_BURST
  always_ff @(posedge SYS_CLK_100M or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_beat    <= 3'd0;
      r_wait    <= 2'd0;
      r_bank    <= 2'd0;
      r_brow    <= '0;
      r_col     <= '0;
      r_data_rd <= 16'h0000;
      r_dqs_rd  <= 2'b00;
      r_data_oe <= 1'b0;
    end else begin
      r_data_rd <= 16'h0000;
      r_dqs_rd  <= 2'b00;
      r_data_oe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rw_ok) begin
            // Row is captured now so later ACTIVE/PRECHARGE cannot disturb this burst
            r_bank  <= bus.BA;
            r_brow  <= r_row[bus.BA];
            r_col   <= bus.ADDR_RAM[COL_BITS-1:0];
            r_beat  <= 3'd0;
            r_wait  <= 2'd0;
            r_state <= (w_cmd == CMD_WR) ? S_WR_BURST : S_RD_WAIT;
          end
        end
        S_WR_BURST: begin
          r_beat <= r_beat + 3'd1;
          if (r_beat == LAST_BEAT) r_state <= S_IDLE;
        end
        S_RD_WAIT: begin
          if (r_wait == LAST_WAIT) r_state <= S_RD_BURST;
          else                     r_wait  <= r_wait + 2'd1;
        end
        S_RD_BURST: begin
          r_data_rd <= r_mem[w_addr];
          r_data_oe <= 1'b1;
          r_dqs_rd  <= r_beat[0] ? 2'b00 : 2'b11;
          r_beat    <= r_beat + 3'd1;
          if (r_beat == LAST_BEAT) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.DATA_RD   = r_data_rd;
  assign bus.DQS_RD    = r_dqs_rd;
  assign bus.DATA_OE   = r_data_oe;
  assign bus.MODE_REG  = r_mode_reg;
  assign bus.REF_COUNT = r_ref_count;
  assign bus.ERR       = r_err;
endmodule

// File: tb/tb_ddr_sdram_responder.sv
// Drives two responders (BL=2/CL=2 and BL=4/CL=3) with identical stimulus and checks both against a behavioural model.
module tb_ddr_sdram_responder;
  localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cke = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [1:0]  ba = 2'd0, dm = 2'd0;
  logic [12:0] addr = 13'd0;
  logic [15:0] dwr = 16'd0;

  ddr_sdram_responder_if bus_a ();
  ddr_sdram_responder_if bus_b ();

  assign bus_a.CKE = cke;  assign bus_a.RAS = ras;  assign bus_a.CAS = cas;  assign bus_a.WE = we;
  assign bus_a.BA = ba;    assign bus_a.ADDR_RAM = addr; assign bus_a.DM = dm; assign bus_a.DATA_WR = dwr;
  assign bus_b.CKE = cke;  assign bus_b.RAS = ras;  assign bus_b.CAS = cas;  assign bus_b.WE = we;
  assign bus_b.BA = ba;    assign bus_b.ADDR_RAM = addr; assign bus_b.DM = dm; assign bus_b.DATA_WR = dwr;

  ddr_sdram_responder #(.BURST_LENGTH(2), .CAS_LATENCY(2), .ROW_BITS(2), .COL_BITS(4)) u_dut_a (
    .SYS_CLK_100M(clk), .RST(rst), .bus(bus_a.slave));
  ddr_sdram_responder #(.BURST_LENGTH(4), .CAS_LATENCY(3), .ROW_BITS(2), .COL_BITS(4)) u_dut_b (
    .SYS_CLK_100M(clk), .RST(rst), .bus(bus_b.slave));

  always #5 clk = ~clk;

  // Behavioural reference: index 0 models u_dut_a, index 1 models u_dut_b
  logic [15:0] m_mem   [2][256];
  logic [1:0]  m_known [2][256];
  bit          m_open  [2][4];
  int          m_row   [2][4];
  bit          m_err   [2];
  logic [15:0] m_ref   [2];
  logic [12:0] m_mode  [2];
  int          m_busy_end [2];
  bit          m_rd [2], m_wr [2];
  int          m_cmd_edge [2], m_bank [2], m_brow [2], m_bcol [2];
  bit          x_oe   [2];
  logic [15:0] x_data [2], x_mask [2];
  logic [1:0]  x_dqs  [2];
  int          edge_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic int bl_of(input int d); return (d == 0) ? 2 : 4; endfunction
  function automatic int cl_of(input int d); return (d == 0) ? 2 : 3; endfunction

  function automatic int beat_addr(input int bank, input int row, input int col, input int i, input int bl);
    int c;
    c = (col / bl) * bl + ((col % bl) + i) % bl;
    return bank * 64 + row * 16 + c;
  endfunction

  function automatic string tag(input int d, input string name);
    return $sformatf("%s.%s", (d == 0) ? "bl2" : "bl4", name);
  endfunction

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 4; b++) begin m_open[d][b] = 1'b0; m_row[d][b] = 0; end
      m_err[d] = 1'b0; m_ref[d] = 16'd0; m_mode[d] = 13'd0;
      m_rd[d] = 1'b0; m_wr[d] = 1'b0; m_busy_end[d] = -1;
      x_oe[d] = 1'b0; x_data[d] = 16'd0; x_dqs[d] = 2'b00; x_mask[d] = 16'hFFFF;
    end
  endtask

  // Apply the command-level rules for one sampled rising edge
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int b, c, i, a;
      b = bl_of(d); c = cl_of(d);
      x_oe[d] = 1'b0; x_data[d] = 16'd0; x_dqs[d] = 2'b00; x_mask[d] = 16'hFFFF;
      if (m_rd[d]) begin
        i = edge_n - m_cmd_edge[d] - c;
        if (i >= 0 && i < b) begin
          a = beat_addr(m_bank[d], m_brow[d], m_bcol[d], i, b);
          x_oe[d]   = 1'b1;
          x_data[d] = m_mem[d][a];
          x_mask[d] = {{8{m_known[d][a][1]}}, {8{m_known[d][a][0]}}};
          x_dqs[d]  = (i % 2 == 0) ? 2'b11 : 2'b00;
        end
      end
      if (m_wr[d]) begin
        i = edge_n - m_cmd_edge[d] - 1;
        if (i >= 0 && i < b) begin
          a = beat_addr(m_bank[d], m_brow[d], m_bcol[d], i, b);
          if (!dm[1]) begin m_mem[d][a][15:8] = dwr[15:8]; m_known[d][a][1] = 1'b1; end
          if (!dm[0]) begin m_mem[d][a][7:0]  = dwr[7:0];  m_known[d][a][0] = 1'b1; end
        end
      end
      if (cke) begin
        case ({ras, cas, we})
          C_ACT: begin
            if (m_open[d][ba]) m_err[d] = 1'b1;
            else begin m_open[d][ba] = 1'b1; m_row[d][ba] = int'(addr[1:0]); end
          end
          C_PRE: begin
            if (addr[10]) for (int k = 0; k < 4; k++) m_open[d][k] = 1'b0;
            else m_open[d][ba] = 1'b0;
          end
          C_REF: begin
            m_ref[d] = m_ref[d] + 16'd1;
            if (m_open[d][0] || m_open[d][1] || m_open[d][2] || m_open[d][3]) m_err[d] = 1'b1;
          end
          C_LMR: m_mode[d] = addr;
          C_RD, C_WR: begin
            if (edge_n <= m_busy_end[d] || !m_open[d][ba]) m_err[d] = 1'b1;
            else begin
              m_rd[d] = ({ras, cas, we} == C_RD);
              m_wr[d] = !m_rd[d];
              m_cmd_edge[d] = edge_n;
              m_bank[d] = int'(ba);
              m_brow[d] = m_row[d][ba];
              m_bcol[d] = int'(addr[3:0]);
              m_busy_end[d] = m_rd[d] ? edge_n + c + b - 1 : edge_n + b;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    logic [15:0] rd, rc;
    logic [1:0]  dq;
    logic [12:0] md;
    logic        oe, er;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        rd = bus_a.DATA_RD; dq = bus_a.DQS_RD; oe = bus_a.DATA_OE;
        er = bus_a.ERR; rc = bus_a.REF_COUNT; md = bus_a.MODE_REG;
      end else begin
        rd = bus_b.DATA_RD; dq = bus_b.DQS_RD; oe = bus_b.DATA_OE;
        er = bus_b.ERR; rc = bus_b.REF_COUNT; md = bus_b.MODE_REG;
      end
      check_eq(tag(d, "oe"),   32'(oe), 32'(x_oe[d]));
      check_eq(tag(d, "data"), 32'(rd & x_mask[d]), 32'(x_data[d] & x_mask[d]));
      check_eq(tag(d, "dqs"),  32'(dq), 32'(x_dqs[d]));
      check_eq(tag(d, "err"),  32'(er), 32'(m_err[d]));
      check_eq(tag(d, "ref"),  32'(rc), 32'(m_ref[d]));
      check_eq(tag(d, "mode"), 32'(md), 32'(m_mode[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (!rst) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    cke = 1'b1; {ras, cas, we} = c; ba = b; addr = a;
    step();
    {ras, cas, we} = C_NOP;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wbeats(input logic [63:0] data, input logic [7:0] masks);
    for (int k = 0; k < 4; k++) begin
      dwr = data[63 - 16 * k -: 16];
      dm  = masks[7 - 2 * k -: 2];
      step();
    end
    dm = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("rst.a.oe", 32'(bus_a.DATA_OE), 32'd0);
    check_eq("rst.a.data", 32'(bus_a.DATA_RD), 32'd0);
    check_eq("rst.b.dqs", 32'(bus_b.DQS_RD), 32'd0);
    compare_all();
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++) begin m_mem[d][w] = 16'd0; m_known[d][w] = 2'b00; end
    model_reset();
    idle(2);
    rst = 1'b0;

    // Write/read round trip, BL=2 unit checked beat by beat
    cmd(C_ACT, 2'd1, 13'd3);
    cmd(C_WR, 2'd1, 13'd4);
    wbeats(64'h7654_FEDC_0000_0000, 8'h00);
    idle(2);
    cmd(C_RD, 2'd1, 13'd4);
    step();
    check_eq("bl2.pre_oe", 32'(bus_a.DATA_OE), 32'd0);
    step();
    check_eq("bl2.b0_oe", 32'(bus_a.DATA_OE), 32'd1);
    check_eq("bl2.b0_data", 32'(bus_a.DATA_RD), 32'h7654);
    check_eq("bl2.b0_dqs", 32'(bus_a.DQS_RD), 32'h3);
    step();
    check_eq("bl2.b1_data", 32'(bus_a.DATA_RD), 32'hFEDC);
    check_eq("bl2.b1_dqs", 32'(bus_a.DQS_RD), 32'h0);
    step();
    check_eq("bl2.post_oe", 32'(bus_a.DATA_OE), 32'd0);
    idle(4);

    // Wrap and byte masks, BL=4 unit
    cmd(C_WR, 2'd1, 13'd4);
    wbeats(64'h1111_2222_3333_4444, 8'h00);
    idle(2);
    cmd(C_WR, 2'd1, 13'd6);
    wbeats(64'hA0A1_B0B1_C0C1_D0D1, 8'b00_01_10_00);
    idle(2);
    cmd(C_RD, 2'd1, 13'd4);
    idle(3);
    check_eq("bl4.col4", 32'(bus_b.DATA_RD), 32'h11C1);
    step(); check_eq("bl4.col5", 32'(bus_b.DATA_RD), 32'hD0D1);
    step(); check_eq("bl4.col6", 32'(bus_b.DATA_RD), 32'hA0A1);
    step(); check_eq("bl4.col7", 32'(bus_b.DATA_RD), 32'hB044);
    idle(3);

    // Reset in the middle of a read, then READ with no open bank
    cmd(C_RD, 2'd1, 13'd4);
    idle(2);
    do_reset();
    cmd(C_RD, 2'd1, 13'd4);
    check_eq("rd_closed.err", 32'(bus_a.ERR & bus_b.ERR), 32'd1);
    idle(6);

    // Protocol errors, each from a clean reset
    do_reset();
    cmd(C_WR, 2'd2, 13'd0);
    wbeats(64'hDEAD_BEEF_0BAD_F00D, 8'h00);
    check_eq("wr_closed.err", 32'(bus_b.ERR), 32'd1);
    do_reset();
    cmd(C_ACT, 2'd0, 13'd0);
    cmd(C_ACT, 2'd0, 13'd1);
    check_eq("act_twice.err", 32'(bus_a.ERR), 32'd1);
    do_reset();
    cmd(C_ACT, 2'd0, 13'd0);
    cmd(C_RD, 2'd0, 13'd0);
    step();
    cmd(C_RD, 2'd0, 13'd0);
    check_eq("rd_busy.err", 32'(bus_a.ERR), 32'd1);
    check_eq("rd_busy.b0_oe", 32'(bus_a.DATA_OE), 32'd1);
    step();
    check_eq("rd_busy.b1_oe", 32'(bus_a.DATA_OE), 32'd1);
    step();
    check_eq("rd_busy.end_oe", 32'(bus_a.DATA_OE), 32'd0);
    idle(6);

    // Mode word, refresh counting and CKE gating
    do_reset();
    cmd(C_LMR, 2'd0, 13'h0022);
    check_eq("mode", 32'(bus_a.MODE_REG), 32'h0022);
    for (int k = 0; k < 3; k++) cmd(C_REF, 2'd0, 13'd0);
    check_eq("ref3", 32'(bus_b.REF_COUNT), 32'd3);
    check_eq("ref3.err", 32'(bus_b.ERR), 32'd0);
    {ras, cas, we} = C_REF; cke = 1'b0;
    step();
    {ras, cas, we} = C_NOP; cke = 1'b1;
    check_eq("ref_cke0", 32'(bus_a.REF_COUNT), 32'd3);

    // Bank isolation
    cmd(C_ACT, 2'd0, 13'd0);
    cmd(C_ACT, 2'd3, 13'd0);
    cmd(C_WR, 2'd0, 13'd0);
    wbeats(64'h1111_0000_0000_0000, 8'h00);
    idle(2);
    cmd(C_WR, 2'd3, 13'd0);
    wbeats(64'h2222_0000_0000_0000, 8'h00);
    idle(2);
    for (int k = 0; k < 2; k++) begin
      cmd(C_RD, (k == 0) ? 2'd0 : 2'd3, 13'd0);
      idle(2);
      check_eq("iso.a", 32'(bus_a.DATA_RD), (k == 0) ? 32'h1111 : 32'h2222);
      step();
      check_eq("iso.b", 32'(bus_b.DATA_RD), (k == 0) ? 32'h1111 : 32'h2222);
      idle(6);
    end

    // Randomized command stream with occasional resets
    for (int n = 0; n < 1500; n++) begin
      int r;
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        r    = int'($urandom_range(0, 99));
        cke  = ($urandom_range(0, 9) != 0);
        ba   = 2'($urandom_range(0, 3));
        addr = 13'($urandom);
        dwr  = 16'($urandom);
        dm   = 2'($urandom_range(0, 3));
        if      (r < 30) {ras, cas, we} = C_NOP;
        else if (r < 45) {ras, cas, we} = C_ACT;
        else if (r < 60) {ras, cas, we} = C_PRE;
        else if (r < 75) {ras, cas, we} = C_RD;
        else if (r < 90) {ras, cas, we} = C_WR;
        else if (r < 95) {ras, cas, we} = C_REF;
        else             {ras, cas, we} = C_LMR;
        step();
      end
    end
    {ras, cas, we} = C_NOP; cke = 1'b1;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
